cla16_add32_scheduler: RTL and testbench

- Shares one external 16-bit carry-lookahead adder between two requesters (ALU port 0, branch/address port 1) and sequences it to perform 32-bit add/subtract in two passes: low half, then high half with the registered carry.
- Round-robin arbitration, valid/ready request and result handshakes, and registered carry/overflow/zero flags.
- Sits between the ALU/branch-target logic and the shared 16-bit CLA instance.

---
 rtl/cla16_add32_scheduler.sv | 238 +++++++++++++++++++++++
 tb/tb_cla16_add32_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cla16_add32_scheduler.sv
// ---------------------------------------------------------------------------
// cla16_add32_scheduler
//
// Purpose:
//   Shares one external 16-bit carry-lookahead adder between two requesters
//   (port 0: ALU, port 1: branch/address) and runs each 32-bit add/subtract
//   through it in two passes. The low half goes first. The high half follows,
//   using the carry registered from the low pass.
//   Requests are arbitrated round-robin. The request and result sides each use
//   a valid/ready handshake. The carry, overflow and zero flags are registered.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst        in   1   synchronous active-low reset
//   req_valid  in   2   per-requester request valid
//   req_ready  out  2   per-requester accept (combinational, IDLE only)
//   req_a0/b0  in  32   requester 0 operands
//   req_a1/b1  in  32   requester 1 operands
//   req_sub    in   2   per-requester op: 1 = a-b, 0 = a+b
//   cla_in1    out 16   shared adder operand 1
//   cla_in2    out 16   shared adder operand 2
//   cla_cin    out  1   shared adder carry in
//   cla_sum    in  16   shared adder sum
//   cla_cout   in   1   shared adder carry out
//   res_valid  out  1   result available
//   res_ready  in   1   consumer accepts result
//   res_id     out  1   requester that owns the result
//   res_sum    out 32   32-bit result
//   res_cout   out  1   carry out of bit 31 (subtract: 1 = no borrow)
//   res_ovf    out  1   signed overflow
//   res_zero   out  1   res_sum == 0
// ---------------------------------------------------------------------------
module cla16_add32_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_sub,
  output logic [15:0] cla_in1,
  output logic [15:0] cla_in2,
  output logic        cla_cin,
  input  logic [15:0] cla_sum,
  input  logic        cla_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        res_zero
);

  localparam int NREQ = 2;
  localparam int W    = 32;
  localparam int HW   = W / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;          // already inverted for subtract
  logic            r_cin0;
  logic            r_id;
  logic            r_last_grant;
  logic            r_carry;      // carry out of the low pass
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_zero;

  logic            w_grant;
  logic [NREQ-1:0] w_ready;
  logic            w_accept;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;
  logic            w_sub_sel;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    w_grant = 1'b0;
    case (req_valid)
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  // Accept handshake and operand selection for the granted requester.
  always_comb begin
    w_ready    = {NREQ{1'b0}};
    w_a_sel    = req_a0;
    w_b_sel    = req_b0;
    w_sub_sel  = req_sub[0];
    if (r_state == S_IDLE) begin
      w_ready[0] = ~w_grant & req_valid[0];
      w_ready[1] =  w_grant & req_valid[1];
    end else begin
      w_ready = {NREQ{1'b0}};
    end
    if (w_grant) begin
      w_a_sel   = req_a1;
      w_b_sel   = req_b1;
      w_sub_sel = req_sub[1];
    end else begin
      w_a_sel   = req_a0;
      w_b_sel   = req_b0;
      w_sub_sel = req_sub[0];
    end
  end

  assign w_accept  = |w_ready;
  assign req_ready = w_ready;

  // Next-state logic for the two-pass sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_LO;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LO:   w_state_nxt = S_HI;
      S_HI:   w_state_nxt = S_DONE;
      S_DONE: begin
        if (res_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture at accept and result capture from each adder pass.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a          <= {W{1'b0}};
      r_b          <= {W{1'b0}};
      r_cin0       <= 1'b0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
      r_carry      <= 1'b0;
      r_sum        <= {W{1'b0}};
      r_cout       <= 1'b0;
      r_ovf        <= 1'b0;
      r_zero       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Subtract is a + ~b + 1, so the +1 rides in on the low carry-in.
            r_a          <= w_a_sel;
            r_b          <= w_sub_sel ? ~w_b_sel : w_b_sel;
            r_cin0       <= w_sub_sel;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
          end else begin
            r_a <= r_a;
          end
        end
        S_LO: begin
          r_sum[HW-1:0] <= cla_sum;
          r_carry       <= cla_cout;
        end
        S_HI: begin
          r_sum[W-1:HW] <= cla_sum;
          r_cout        <= cla_cout;
          // Overflow: same-sign operands giving a different-sign result.
          r_ovf         <= (r_a[W-1] == r_b[W-1]) && (cla_sum[HW-1] != r_a[W-1]);
          r_zero        <= (cla_sum == {HW{1'b0}}) && (r_sum[HW-1:0] == {HW{1'b0}});
        end
        S_DONE: begin
          r_sum <= r_sum;
        end
        default: begin
          r_sum <= r_sum;
        end
      endcase
    end
  end

  // Drive the shared adder only while a pass is in flight; park it at zero otherwise.
  always_comb begin
    cla_in1 = {HW{1'b0}};
    cla_in2 = {HW{1'b0}};
    cla_cin = 1'b0;
    case (r_state)
      S_LO: begin
        cla_in1 = r_a[HW-1:0];
        cla_in2 = r_b[HW-1:0];
        cla_cin = r_cin0;
      end
      S_HI: begin
        cla_in1 = r_a[W-1:HW];
        cla_in2 = r_b[W-1:HW];
        cla_cin = r_carry;
      end
      default: begin
        cla_in1 = {HW{1'b0}};
        cla_in2 = {HW{1'b0}};
        cla_cin = 1'b0;
      end
    endcase
  end

  assign res_valid = (r_state == S_DONE);
  assign res_id    = r_id;
  assign res_sum   = r_sum;
  assign res_cout  = r_cout;
  assign res_ovf   = r_ovf;
  assign res_zero  = r_zero;

endmodule

// File: tb/tb_cla16_add32_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cla16_add32_scheduler
//
// Self-checking bench. It models the shared 16-bit adder behaviourally. Each
// expected result is computed from whole 32-bit arithmetic: unsigned for the
// sum and carry, and signed 64-bit for overflow. Round-robin order is tracked
// with a single last-winner variable.
// ---------------------------------------------------------------------------
module tb_cla16_add32_scheduler;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0]  req_sub;
  logic [15:0] cla_in1, cla_in2;
  logic        cla_cin;
  logic [15:0] cla_sum;
  logic        cla_cout;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [31:0] res_sum;
  logic        res_cout, res_ovf, res_zero;

  int n_total = 0;
  int n_bad   = 0;
  logic model_last;

  cla16_add32_scheduler dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub),
    .cla_in1(cla_in1), .cla_in2(cla_in2), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_cout(res_cout), .res_ovf(res_ovf), .res_zero(res_zero)
  );

  // Behavioural stand-in for the shared 16-bit CLA.
  assign {cla_cout, cla_sum} = {1'b0, cla_in1} + {1'b0, cla_in2} + {16'd0, cla_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return ~last;
    return v[1];
  endfunction

  // One full transaction: accept, low pass, high pass, result (optionally stalled).
  task automatic run_op(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] b0,
                        input logic [31:0] a1, input logic [31:0] b1,
                        input logic [1:0] sub, input int stall);
    logic        g, s, lc, ec, eo;
    logic [31:0] a, b, es;
    logic [32:0] u;
    logic [15:0] bl, bh;
    longint      r;
    @(negedge clk);
    chk("valid_dropped", res_valid, 1'b0);
    req_valid = v; req_a0 = a0; req_b0 = b0; req_a1 = a1; req_b1 = b1;
    req_sub = sub; res_ready = 1'b0;
    #1;
    g = pick(v, model_last);
    chk("ready_idle", req_ready, g ? 2'b10 : 2'b01);
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    s  = sub[g];
    bl = s ? ~b[15:0]  : b[15:0];
    bh = s ? ~b[31:16] : b[31:16];
    lc = s ? (a[15:0] >= b[15:0]) : (({1'b0, a[15:0]} + {1'b0, b[15:0]}) > 17'h0FFFF);
    u  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    es = u[31:0];
    ec = s ? (a >= b) : u[32];
    r  = s ? (longint'($signed(a)) - longint'($signed(b)))
           : (longint'($signed(a)) + longint'($signed(b)));
    eo = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    model_last = g;

    @(negedge clk);  // LO
    chk("lo_in1", cla_in1, a[15:0]);
    chk("lo_in2", cla_in2, bl);
    chk("lo_cin", cla_cin, s);
    chk("lo_ready", req_ready, 2'b00);
    chk("lo_valid", res_valid, 1'b0);
    // Operands after acceptance must not leak into the result.
    req_a0 = $urandom; req_b0 = $urandom; req_a1 = $urandom; req_b1 = $urandom;
    req_sub = 2'($urandom_range(0, 3));

    @(negedge clk);  // HI
    chk("hi_in1", cla_in1, a[31:16]);
    chk("hi_in2", cla_in2, bh);
    chk("hi_cin", cla_cin, lc);
    chk("hi_ready", req_ready, 2'b00);
    chk("hi_valid", res_valid, 1'b0);

    @(negedge clk);  // DONE
    chk("res_valid", res_valid, 1'b1);
    chk("res_id", res_id, g);
    chk("res_sum", res_sum, es);
    chk("res_cout", res_cout, ec);
    chk("res_ovf", res_ovf, eo);
    chk("res_zero", res_zero, (es == 32'd0));
    chk("done_ready", req_ready, 2'b00);
    chk("done_cla", {cla_in1, cla_in2, cla_cin}, 33'd0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", res_valid, 1'b1);
      chk("stall_sum", res_sum, es);
      chk("stall_ready", req_ready, 2'b00);
    end
    res_ready = 1'b1;
    req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b0; req_valid = 2'b00; req_sub = 2'b00; res_ready = 1'b0;
    req_a0 = 32'd0; req_b0 = 32'd0; req_a1 = 32'd0; req_b1 = 32'd0;
    model_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_sum", res_sum, 32'd0);
    chk("rst_flags", {res_cout, res_ovf, res_zero, res_id}, 4'd0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_cla", {cla_in1, cla_in2, cla_cin}, 33'd0);
    rst = 1'b1;

    // Fairness with both requesters asking: 0, 1, 0, 1.
    for (int i = 0; i < 4; i++)
      run_op(2'b11, 32'h1000 + 32'(i), 32'd3, 32'h2000 + 32'(i), 32'd5, 2'b01, 0);

    // Directed corners.
    run_op(2'b01, 32'h0000FFFF, 32'h00000001, 32'd0, 32'd0, 2'b00, 0);
    run_op(2'b10, 32'd0, 32'd0, 32'd5, 32'd7, 2'b10, 0);
    run_op(2'b01, 32'd7, 32'd7, 32'd0, 32'd0, 2'b01, 0);
    run_op(2'b10, 32'd0, 32'd0, 32'h7FFFFFFF, 32'd1, 2'b00, 0);
    run_op(2'b01, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 2'b00, 0);
    run_op(2'b10, 32'd0, 32'd0, 32'h80000000, 32'd1, 2'b10, 0);
    run_op(2'b01, 32'h12345678, 32'h0FEDCBA9, 32'd0, 32'd0, 2'b00, 5);

    // Reset while in HI.
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = 2'b01; req_a0 = 32'hABCD1234; req_b0 = 32'h11111111; req_sub = 2'b00;
    @(negedge clk);  // LO
    req_valid = 2'b00;
    @(negedge clk);  // HI
    chk("hi_before_rst", cla_in1, 16'hABCD);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    chk("mrst_valid", res_valid, 1'b0);
    chk("mrst_sum", res_sum, 32'd0);
    chk("mrst_flags", {res_cout, res_ovf, res_zero, res_id}, 4'd0);
    chk("mrst_cla", {cla_in1, cla_in2, cla_cin}, 33'd0);
    chk("mrst_ready", req_ready, 2'b00);

    // Reset and a request at the same edge: reset wins, nothing accepted.
    rst = 1'b0;
    req_valid = 2'b01; req_a0 = 32'h0000BEEF; req_b0 = 32'd1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_win_cla", {cla_in1, cla_in2, cla_cin}, 33'd0);
    chk("rst_win_idle", req_ready, 2'b01);
    req_valid = 2'b00;

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
      if ((i % 5) == 0) ra0 = 32'hFFFFFFFF;
      if ((i % 7) == 0) rb1 = ra1;
      run_op(2'($urandom_range(1, 3)), ra0, rb0, ra1, rb1,
             2'($urandom_range(0, 3)), $urandom_range(0, 2));
    end

    @(negedge clk);
    chk("final_idle", res_valid, 1'b0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
